// File: rtl/fetch_if.sv
// Instruction-memory bus between the FETCH stage and the instruction cache.
// The fetch stage drives the address and request; the cache answers in the
// same cycle with an ack and the instruction word.
interface fetch_if;
  logic [31:0] IMEM_ADDR;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] IMEM_DATA;

  modport master (
    output IMEM_ADDR,
    output imem_req,
    input  imem_ack,
    input  IMEM_DATA
  );

  modport slave (
    input  IMEM_ADDR,
    input  imem_req,
    output imem_ack,
    output IMEM_DATA
  );
endinterface

// File: rtl/fetch.sv
// FETCH stage: owns the PC, reads the instruction cache and loads the IF/ID
// register consumed by DECODE. A direct-mapped BTB with 2-bit saturating
// counters predicts the next PC; EXECUTE trains it and may flush/redirect.
// A one-entry skid buffer keeps a word that arrived while the pipe stalled.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BTB_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     imem,
  input  logic        hazard_stall,
  input  logic        cache_stall,
  input  logic        flush,
  input  logic [31:0] REDIRECT_PC,
  input  logic        bp_update,
  input  logic [31:0] UPDATE_PC,
  input  logic [31:0] UPDATE_TARGET,
  input  logic        update_taken,
  output logic [31:0] NEXT_PC,
  output logic [31:0] INSTRUCTION,
  output logic        prediction
);

  localparam int ENTRIES = 1 << BTB_BITS;
  localparam int TAG_W   = 30 - BTB_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        pred;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  ifid_t       skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic             btb_valid  [ENTRIES];
  logic [1:0]       btb_ctr    [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];

  logic              stall;
  logic [31:0]       pc_plus4;
  logic [BTB_BITS-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0]  look_tag, upd_tag;
  logic              look_hit, pred_taken, upd_hit;
  logic [31:0]       pred_pc;
  ifid_t             fetched;
  logic              unused_low_bits;

  assign stall    = hazard_stall | cache_stall;
  assign pc_plus4 = pc_q + 32'd4;

  // BTB lookup on the current PC; reads see contents before any same-cycle update.
  assign look_idx   = pc_q[BTB_BITS+1:2];
  assign look_tag   = pc_q[31:BTB_BITS+2];
  assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_taken = look_hit && btb_ctr[look_idx][1];
  assign pred_pc    = pred_taken ? btb_target[look_idx] : pc_plus4;

  assign fetched.instr   = imem.IMEM_DATA;
  assign fetched.next_pc = pc_plus4;
  assign fetched.pred    = pred_taken;

  assign upd_idx = UPDATE_PC[BTB_BITS+1:2];
  assign upd_tag = UPDATE_PC[31:BTB_BITS+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  // Byte offset of the branch PC carries no information for the BTB.
  assign unused_low_bits = ^UPDATE_PC[1:0];

  assign imem.IMEM_ADDR = pc_q;
  assign imem.imem_req  = (state_q == FETCH);

  assign NEXT_PC     = ifid_q.next_pc;
  assign INSTRUCTION = ifid_q.instr;
  assign prediction  = ifid_q.pred;

  // Next-state logic: flush beats stall beats normal flow.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      pc_d      = REDIRECT_PC;
      ifid_d    = '0;
      skid_d    = '0;
      skid_pc_d = '0;
      state_d   = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem.imem_ack && !stall) begin
            ifid_d = fetched;
            pc_d   = pred_pc;
          end else if (imem.imem_ack) begin
            skid_d    = fetched;
            skid_pc_d = pred_pc;
            state_d   = HOLD;
          end else if (!stall) begin
            ifid_d = '0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d  = skid_q;
            pc_d    = skid_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pipeline state registers: PC, IF/ID, skid buffer and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ifid_q    <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  // BTB valid bits and saturating direction counters, trained by EXECUTE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b00;
      end
    end else if (bp_update) begin
      if (upd_hit) begin
        if (update_taken && btb_ctr[upd_idx] != 2'b11)
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
        else if (!update_taken && btb_ctr[upd_idx] != 2'b00)
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
      end else if (update_taken) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_ctr[upd_idx]   <= 2'b10;
      end
    end
  end

  // BTB tag and target storage, written on every taken resolution.
  always_ff @(posedge clk) begin
    // NOTE: tags and targets are not reset; the cleared valid bits make their contents irrelevant.
    if (reset && bp_update && update_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= UPDATE_TARGET;
    end
  end

endmodule
